// File: rtl/vsync_generator_pkg.sv
// ----------------------------------------------------------------------------
// vsync_generator_pkg
//   Constants and types shared by the laser-controller timing blocks:
//   - state_t     : frame sequencer state encoding (IDLE, PULSE, GAP)
//   - LFSR_SEED   : reset value of the jitter LFSR (nonzero, reproducible)
//   - MIN_PERIOD  : smallest frame period accepted; shorter requests clamp up
//   - JITTER_W    : width of the per-frame jitter draw (0..15 extra cycles)
// ----------------------------------------------------------------------------
package vsync_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          MIN_PERIOD = 2;
  localparam int          JITTER_W   = 4;

endpackage : vsync_generator_pkg

// File: rtl/vsync_generator_lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16
//   16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length). Advances one
//   step per cycle while en is high; synchronous active-high reset reloads
//   LFSR_SEED so the sequence is reproducible after every reset.
//   Only compiled when the VSYNC_JITTER_EN macro is defined.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   en   in  advance enable
//   q    out current LFSR state
// ----------------------------------------------------------------------------
`ifdef VSYNC_JITTER_EN
module lfsr16
  import vsync_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic feedback;

  // Tap positions 16,14,13,11 counted from 1 map to bits 15,13,12,10.
  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], feedback};
    end
  end

endmodule : lfsr16
`endif

// File: rtl/vsync_generator.sv
// ----------------------------------------------------------------------------
// vsync_generator
//   Camera-style frame sync for the laser controller. Each frame drives
//   V_SYNC active for the latched pulse width, then inactive until the
//   latched period has elapsed since frame start. Back-to-back frames run
//   with no idle cycle while EN stays high; dropping EN lets the current
//   frame finish. PERIOD/PULSE_W/POLARITY are captured only at frame start.
//   Clamps: period < 2 -> 2, width 0 -> 1, width >= period -> period-1.
//
//   Optional macro VSYNC_JITTER_EN: adds 0..15 extra GAP cycles per frame,
//   drawn from lfsr16 at each frame start. Undefined: exact period, no LFSR.
//
// Ports:
//   CLK          in   30 MHz clock, all logic on rising edge
//   RST          in   synchronous active-high reset
//   EN           in   run request (level)
//   PERIOD       in   frame period in CLK cycles          [PERIOD_W]
//   PULSE_W      in   V_SYNC active width in CLK cycles   [PULSE_W_W]
//   POLARITY     in   active level of V_SYNC (1 = high)
//   V_SYNC       out  registered frame sync
//   FRAME_START  out  one-cycle strobe on first cycle of each frame
//   FRAME_CNT    out  frames started since reset, wraps  [CNT_W]
//   BUSY         out  high while a frame is in progress
// ----------------------------------------------------------------------------
module vsync_generator
  import vsync_generator_pkg::*;
#(
  parameter int PERIOD_W  = 28,
  parameter int PULSE_W_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [PERIOD_W-1:0]  PERIOD,
  input  logic [PULSE_W_W-1:0] PULSE_W,
  input  logic                 POLARITY,
  output logic                 V_SYNC,
  output logic                 FRAME_START,
  output logic [CNT_W-1:0]     FRAME_CNT,
  output logic                 BUSY
);

  // Working width for clamp arithmetic: wide enough for either input plus
  // the jitter addition without wrapping.
  localparam int XW = ((PERIOD_W > PULSE_W_W) ? PERIOD_W : PULSE_W_W) + 1;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = {PERIOD_W{1'b1}};

  state_t                state;
  logic [PERIOD_W-1:0]   cnt_q;        // cycle index within current frame
  logic [PERIOD_W-1:0]   pulse_end_q;  // last PULSE cycle index
  logic [PERIOD_W-1:0]   frame_end_q;  // last GAP cycle index
  logic                  pol_q;

  logic [PERIOD_W-1:0]   pulse_end_d;
  logic [PERIOD_W-1:0]   frame_end_d;
  logic [JITTER_W-1:0]   jitter;
  logic                  start_frame;

  logic [XW-1:0]         per_x;
  logic [XW-1:0]         wid_x;
  logic [XW-1:0]         end_x;

  // A frame starts from IDLE on any EN sample, or straight out of the last
  // GAP cycle when EN is still high, so consecutive frames abut exactly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default here would infer a latch.
    start_frame = 1'b0;
    unique case (state)
      IDLE:    start_frame = EN;
      GAP:     start_frame = EN && (cnt_q == frame_end_q);
      default: start_frame = 1'b0;
    endcase
  end

`ifdef VSYNC_JITTER_EN
  logic [15:0] lfsr_q;

  // The LFSR steps once per frame start, so each frame draws a fresh value.
  lfsr16 u_lfsr16 (
    .clk (CLK),
    .rst (RST),
    .en  (start_frame),
    .q   (lfsr_q)
  );

  assign jitter = lfsr_q[JITTER_W-1:0];
`else
  assign jitter = '0;
`endif

  // Effective frame parameters computed from the live inputs; they only
  // matter on the start_frame cycle, when they are captured.
  always_comb begin
    per_x = XW'(PERIOD);
    if (per_x < XW'(MIN_PERIOD)) per_x = XW'(MIN_PERIOD);

    wid_x = XW'(PULSE_W);
    if (wid_x == '0)    wid_x = XW'(1);
    // Keep at least one inactive cycle in every frame.
    if (wid_x >= per_x) wid_x = per_x - XW'(1);

    end_x = per_x - XW'(1) + XW'(jitter);
    // Saturate so the frame counter never has to exceed PERIOD_W bits.
    if (end_x > XW'(PERIOD_MAX)) end_x = XW'(PERIOD_MAX);

    pulse_end_d = PERIOD_W'(wid_x - XW'(1));
    frame_end_d = PERIOD_W'(end_x);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous; it clears control state, outputs and the
    // latched frame parameters together on the next edge.
    if (RST) begin
      state       <= IDLE;
      cnt_q       <= '0;
      pulse_end_q <= '0;
      frame_end_q <= '0;
      pol_q       <= 1'b0;
      V_SYNC      <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= '0;
      BUSY        <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      if (start_frame) begin
        state       <= PULSE;
        cnt_q       <= '0;
        pulse_end_q <= pulse_end_d;
        frame_end_q <= frame_end_d;
        pol_q       <= POLARITY;
        V_SYNC      <= POLARITY;
        FRAME_START <= 1'b1;
        FRAME_CNT   <= FRAME_CNT + CNT_W'(1);
        BUSY        <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            // V_SYNC holds its inactive level between frames.
          end
          PULSE: begin
            cnt_q <= cnt_q + PERIOD_W'(1);
            if (cnt_q == pulse_end_q) begin
              state  <= GAP;
              V_SYNC <= ~pol_q;
            end
          end
          GAP: begin
            // Reaching here on the last cycle means EN was low: stop.
            if (cnt_q == frame_end_q) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + PERIOD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule : vsync_generator

// File: tb/tb_vsync_generator.sv
// ----------------------------------------------------------------------------
// tb_vsync_generator
//   Self-checking bench for vsync_generator (CNT_W = 4 so the frame counter
//   wraps quickly). A frame-level reference model tracks position within the
//   current frame and derives every expected output each cycle; directed
//   scenarios add frame-length / pulse-width checks against fixed values.
// ----------------------------------------------------------------------------
module tb_vsync_generator;

  localparam int PERIOD_W  = 28;
  localparam int PULSE_W_W = 16;
  localparam int CNT_W     = 4;
`ifdef VSYNC_JITTER_EN
  localparam int JIT_MAX   = 15;
`else
  localparam int JIT_MAX   = 0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 EN;
  logic [PERIOD_W-1:0]  PERIOD;
  logic [PULSE_W_W-1:0] PULSE_W;
  logic                 POLARITY;
  logic                 V_SYNC;
  logic                 FRAME_START;
  logic [CNT_W-1:0]     FRAME_CNT;
  logic                 BUSY;

  vsync_generator #(
    .PERIOD_W  (PERIOD_W),
    .PULSE_W_W (PULSE_W_W),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .PERIOD      (PERIOD),
    .PULSE_W     (PULSE_W),
    .POLARITY    (POLARITY),
    .V_SYNC      (V_SYNC),
    .FRAME_START (FRAME_START),
    .FRAME_CNT   (FRAME_CNT),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame length must be exactly p, or within [p, p+JIT_MAX] with jitter.
  task automatic check_len(input string tag, input int len, input int p);
    check(tag, (len >= p && len <= p + JIT_MAX) ? p : len, p);
  endtask

  // ---------------- reference model (frame-level) ----------------
  logic        m_vs, m_fs, m_busy, m_pol;
  logic [CNT_W-1:0] m_cnt;
  int unsigned m_pos, m_len, m_wid;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_update();
    int unsigned per, wid;
    logic        start;
    if (RST) begin
      m_busy = 1'b0; m_vs = 1'b0; m_fs = 1'b0; m_cnt = '0; m_pol = 1'b0;
      m_pos = 0; m_len = 0; m_wid = 0; m_lfsr = 16'hACE1;
    end else begin
      start = 1'b0;
      m_fs  = 1'b0;
      if (!m_busy) begin
        start = EN;
      end else if (m_pos == m_len - 1) begin
        if (EN) start = 1'b1;
        else begin
          m_busy = 1'b0;
          m_vs   = ~m_pol;
        end
      end else begin
        m_pos++;
        m_vs = (m_pos < m_wid) ? m_pol : ~m_pol;
      end
      if (start) begin
        per = (PERIOD < 2) ? 2 : int'(PERIOD);
        wid = (PULSE_W == 0) ? 1 : int'(PULSE_W);
        if (wid >= per) wid = per - 1;
        m_len = per;
`ifdef VSYNC_JITTER_EN
        m_len  = m_len + m_lfsr[3:0];
        m_lfsr = lfsr_next(m_lfsr);
`endif
        m_wid  = wid;
        m_pol  = POLARITY;
        m_pos  = 0;
        m_busy = 1'b1;
        m_fs   = 1'b1;
        m_cnt  = m_cnt + 1'b1;
        m_vs   = POLARITY;
      end
    end
  endtask

  // ---------------- cycle stepping and observation ----------------
  int   cyc = 0;
  int   fs_times[$];
  int   act_cnt;
  logic act_pol;
  int   idle_cyc;

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check("v_sync",      V_SYNC,      m_vs);
    check("frame_start", FRAME_START, m_fs);
    check("frame_cnt",   FRAME_CNT,   m_cnt);
    check("busy",        BUSY,        m_busy);
    cyc++;
    if (FRAME_START === 1'b1) fs_times.push_back(cyc);
    if (BUSY === 1'b1 && V_SYNC === act_pol) act_cnt++;
  endtask

  task automatic run_until_fs(input int n);
    int b = 0;
    while (fs_times.size() < n && b < 1000) begin
      step();
      b++;
    end
    check("fs_count_reached", fs_times.size(), n);
  endtask

  task automatic run_until_idle();
    int b = 0;
    while (BUSY !== 1'b0 && b < 1000) begin
      step();
      b++;
    end
    check("idle_reached", BUSY, 1'b0);
    idle_cyc = cyc;
  endtask

  task automatic start_scenario(input int p, input int w, input logic pol);
    PERIOD   = PERIOD_W'(p);
    PULSE_W  = PULSE_W_W'(w);
    POLARITY = pol;
    act_pol  = pol;
    act_cnt  = 0;
    fs_times.delete();
    EN = 1'b1;
  endtask

`ifdef VSYNC_JITTER_EN
  task automatic capture_lengths(output int lens[5]);
    RST = 1'b1; EN = 1'b0;
    step();
    RST = 1'b0;
    start_scenario(5, 2, 1'b1);
    run_until_fs(6);
    EN = 1'b0;
    run_until_idle();
    for (int i = 0; i < 5; i++) begin
      lens[i] = fs_times[i+1] - fs_times[i];
      check_len("jit_len", lens[i], 5);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; EN = 1'b0; PERIOD = '0; PULSE_W = '0; POLARITY = 1'b1;
    act_pol = 1'b1; act_cnt = 0;

    // Reset state
    repeat (3) step();
    check("reset_vsync", V_SYNC, 1'b0);
    check("reset_cnt",   FRAME_CNT, 0);
    RST = 1'b0;
    repeat (2) step();

    // Three frames of 10 cycles, 3 active
    start_scenario(10, 3, 1'b1);
    run_until_fs(3);
    EN = 1'b0;
    run_until_idle();
    check("basic_frames", fs_times.size(), 3);
    check_len("basic_len0", fs_times[1] - fs_times[0], 10);
    check_len("basic_len1", fs_times[2] - fs_times[1], 10);
    check_len("basic_len2", idle_cyc - fs_times[2], 10);
    check("basic_active", act_cnt, 9);
    check("basic_cnt",    FRAME_CNT, 3);
    repeat (2) step();

    // Mid-frame PERIOD change applies only to the next frame
    start_scenario(10, 3, 1'b1);
    run_until_fs(1);
    repeat (2) step();
    PERIOD = PERIOD_W'(20);
    run_until_fs(3);
    EN = 1'b0;
    run_until_idle();
    check_len("chg_len_cur",  fs_times[1] - fs_times[0], 10);
    check_len("chg_len_next", fs_times[2] - fs_times[1], 20);
    repeat (2) step();

    // Clamp: width >= period
    start_scenario(4, 9, 1'b1);
    run_until_fs(1);
    EN = 1'b0;
    run_until_idle();
    check("clamp_w_active", act_cnt, 3);
    check_len("clamp_w_len", idle_cyc - fs_times[0], 4);
    step();

    // Clamp: zero period and width, active-low
    start_scenario(0, 0, 1'b0);
    run_until_fs(1);
    EN = 1'b0;
    run_until_idle();
    check("clamp0_active", act_cnt, 1);
    check_len("clamp0_len", idle_cyc - fs_times[0], 2);
    check("clamp0_idle_vs", V_SYNC, 1'b1);
    step();

    // EN dropped at cycle 2: frame still completes
    start_scenario(10, 3, 1'b1);
    run_until_fs(1);
    repeat (2) step();
    EN = 1'b0;
    run_until_idle();
    check_len("endrop_len", idle_cyc - fs_times[0], 10);
    repeat (4) step();
    check("endrop_vs",   V_SYNC, 1'b0);
    check("endrop_busy", BUSY, 1'b0);

    // RST at cycle 5 aborts the frame
    start_scenario(10, 3, 1'b1);
    run_until_fs(1);
    repeat (5) step();
    RST = 1'b1;
    step();
    check("rst_vsync", V_SYNC, 1'b0);
    check("rst_fs",    FRAME_START, 1'b0);
    check("rst_cnt",   FRAME_CNT, 0);
    check("rst_busy",  BUSY, 1'b0);
    step();
    RST = 1'b0;
    step();
    check("post_rst_fs",  FRAME_START, 1'b1);
    check("post_rst_cnt", FRAME_CNT, 1);
    EN = 1'b0;
    run_until_idle();

    // Counter wrap: 17 frames from reset on a 4-bit counter
    RST = 1'b1;
    step();
    RST = 1'b0;
    start_scenario(3, 1, 1'b1);
    run_until_fs(17);
    EN = 1'b0;
    run_until_idle();
    check("wrap_cnt", FRAME_CNT, 1);

`ifdef VSYNC_JITTER_EN
    begin
      int first[5];
      int second[5];
      capture_lengths(first);
      capture_lengths(second);
      for (int i = 0; i < 5; i++) check("jit_repeat", second[i], first[i]);
    end
`endif

    // Randomized run against the model
    for (int i = 0; i < 800; i++) begin
      EN       = ($urandom_range(0, 9) != 0);
      PERIOD   = PERIOD_W'($urandom_range(0, 24));
      PULSE_W  = PULSE_W_W'($urandom_range(0, 26));
      POLARITY = 1'($urandom_range(0, 1));
      RST      = ($urandom_range(0, 199) == 0);
      step();
    end
    RST = 1'b0;
    EN  = 1'b0;
    run_until_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vsync_generator

// File: doc/vsync_generator.md
VSYNC_GENERATOR -- requirements
Module: vsync_generator

Interface
REQ-001 SHALL have parameter PERIOD_W, default 28: width of the frame period count (covers 1_000_000 cycles at 30 MHz, i.e. 30 FPS).
REQ-002 SHALL have parameter PULSE_W_W, default 16: width of the pulse-width count.
REQ-003 SHALL have parameter CNT_W, default 16: width of the frame counter.
REQ-004 SHALL have port CLK  input  1: the single clock (30 MHz PLL domain); one clock, all logic on its rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port EN  input  1: run request; level-sensitive.
REQ-007 SHALL have port PERIOD  input  PERIOD_W: frame period in CLK cycles.
REQ-008 SHALL have port PULSE_W  input  PULSE_W_W: V_SYNC active width in CLK cycles.
REQ-009 SHALL have port POLARITY  input  1: active level of V_SYNC (1 = active-high).
REQ-010 SHALL have port V_SYNC  output  1: registered camera-style frame sync toward the laser controller.
REQ-011 SHALL have port FRAME_START  output  1: one-cycle strobe on the first active cycle of each frame.
REQ-012 SHALL have port FRAME_CNT  output  CNT_W: frames emitted since reset.
REQ-013 SHALL have port BUSY  output  1: high while a frame is in progress.

Function
REQ-014 SHALL implement FSM states IDLE, PULSE and GAP.
REQ-015 In IDLE with EN=1 sampled at cycle n, SHALL enter PULSE at n+1 with V_SYNC active, FRAME_START=1 and BUSY=1.
REQ-016 SHALL latch PERIOD, PULSE_W and POLARITY only on the cycle a frame starts; input changes mid-frame SHALL NOT affect the current frame.
REQ-017 PULSE SHALL last exactly the latched width; then GAP SHALL run until exactly the latched period has elapsed from frame start.
REQ-018 At the end of GAP with EN=1, SHALL start the next frame on the following cycle with no idle cycle; with EN=0, SHALL go to IDLE with BUSY=0.
REQ-019 EN deasserting mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-020 SHALL clamp PERIOD < 2 to 2 and PULSE_W = 0 to 1; if PULSE_W >= PERIOD, the effective width SHALL be PERIOD-1, so at least one inactive cycle always exists.
REQ-021 FRAME_CNT SHALL increment at each FRAME_START and wrap from all-ones to 0.
REQ-022 V_SYNC SHALL be the inactive level (~POLARITY as latched) in IDLE and GAP.
REQ-023 Counters SHALL be unsigned, sized to the latched width, with no overflow past PERIOD_W.

Reset
REQ-024 RST=1 SHALL force IDLE, V_SYNC=0, FRAME_START=0, FRAME_CNT=0, BUSY=0 and clear all latches on the next edge.
REQ-025 RST asserted mid-frame SHALL abort the frame immediately; a frame SHALL start only on an EN=1 sample after RST is released.

Configuration
REQ-026 Macro VSYNC_JITTER_EN: when defined, an LFSR SHALL add 0..15 extra GAP cycles per frame to emulate camera timing jitter, drawn once per frame at frame start; when undefined, the period SHALL be exact and no LFSR logic SHALL exist.
REQ-027 With VSYNC_JITTER_EN, the LFSR SHALL reseed to a fixed nonzero value (16'hACE1) on RST, so jitter sequences are reproducible.

Structure
REQ-028 The FSM state encoding, the LFSR seed and the clamp minimum (2) SHALL live in the shared package used by the laser-controller blocks.
REQ-029 The jitter source SHALL be sub-module lfsr16 (16-bit Fibonacci with taps 16,14,13,11, enable input, synchronous reset), instantiated only under VSYNC_JITTER_EN.

Verification
REQ-030 Reset then EN=1 with PERIOD=10 and PULSE_W=3, for 3 frames -> V_SYNC high 3 cycles and low 7, FRAME_START every 10 cycles, FRAME_CNT=3.
REQ-031 Change PERIOD from 10 to 20 mid-frame -> the current frame stays 10 cycles and the next frame is 20 cycles.
REQ-032 PERIOD=4 with PULSE_W=9, and PERIOD=0 with PULSE_W=0 -> widths 3/1 and 1/1 respectively.
REQ-033 EN dropped at cycle 2 of a 10-cycle frame -> the frame completes, then BUSY=0 and V_SYNC stays inactive; RST at cycle 5 of a frame -> all outputs are 0 on the next edge.
REQ-034 Preload FRAME_CNT near all-ones (CNT_W forced to 4) and run 17 frames -> the counter wraps to 1; with VSYNC_JITTER_EN, every period falls in [PERIOD, PERIOD+15] and the sequence repeats after reset.
